alarm_sequencer: RTL
====================

# alarm_sequencer

Alarm ringing controller for the alarm clock. Compares the running clock time against the stored alarm time and drives the buzzer and ringing indication through a small state machine with dismiss, snooze (bounded count) and auto-timeout. It sits beside the time-adjust logic and consumes the same debounced one-cycle `button_out` pulses. It is inhibited while the adjust mode is active.

## Interface
Parameters:
- `SNOOZE_SEC`, 300: snooze duration in 1 Hz ticks.
- `RING_SEC`, 60: maximum ringing duration before auto-dismiss, in ticks.
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event.
- `CNT_W`, 9: width of the second counters; must hold max(`SNOOZE_SEC`, `RING_SEC`).

Ports:
- `clk`  in  1  system clock; one clock, all state on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `tick_1hz`  in  1  one-cycle pulse, once per second.
- `button_out`  in  5  debounced one-cycle pulses: [0] centre, [1] left, [2] right, [3] up, [4] down.
- `alarm_enable`  in  1  alarm on/off switch, level.
- `adjust_active`  in  1  high while time or alarm is being adjusted.
- `time_hours`, `alarm_hours`  in  5  binary hours 0..23.
- `time_minutes`, `alarm_minutes`  in  6  binary minutes 0..59.
- `state_out`  out  2  0 DISARMED, 1 ARMED, 2 RINGING, 3 SNOOZE.
- `ringing`  out  1  high in RINGING.
- `buzzer`  out  1  gated beep, toggles each second while ringing.
- `snooze_left`  out  CNT_W  seconds remaining in SNOOZE, else 0.
- `snooze_count`  out  3  snoozes used in the current alarm event.

## Operation
- `match` = (`time_hours`==`alarm_hours`) && (`time_minutes`==`alarm_minutes`), combinational. `match_d` registers `match` every cycle, independent of state.
- `trigger` = `match` && !`match_d` && !`adjust_active`. A trigger is a rising edge only, so a dismiss inside the matching minute never re-rings.
- Priority within one cycle, highest first:
  1. `alarm_enable`==0.
  2. `adjust_active`.
  3. Centre button.
  4. Snooze button (any of [4:1]).
  5. `tick_1hz`.
  A tick coinciding with a button is ignored.
- DISARMED:
  - `alarm_enable`==1 goes to ARMED.
- ARMED:
  - `alarm_enable`==0 goes to DISARMED.
  - `trigger` goes to RINGING. Load `ring_left`=`RING_SEC`, `beep`=1.
- RINGING:
  - `alarm_enable`==0 goes to DISARMED.
  - `adjust_active` or centre goes to ARMED, with `snooze_count`=0.
  - A snooze button with `snooze_count`<`MAX_SNOOZE` goes to SNOOZE. Load `snooze_left`=`SNOOZE_SEC` and increment `snooze_count`.
  - A snooze button with `snooze_count`==`MAX_SNOOZE` is ignored.
  - On a tick, if `ring_left`==1, go to ARMED with `snooze_count`=0. Otherwise decrement `ring_left` and toggle `beep`.
- SNOOZE:
  - `alarm_enable`==0 goes to DISARMED.
  - `adjust_active` or centre goes to ARMED, with `snooze_count`=0.
  - Snooze buttons are ignored.
  - On a tick, if `snooze_left`==1, go to RINGING: `snooze_left`=0, reload `ring_left`=`RING_SEC`, `beep`=1. Otherwise decrement `snooze_left`.
- Every exit to DISARMED clears `snooze_count`, `snooze_left` and `ring_left`.
- `buzzer` = `ringing` && `beep`.
- Counters never wrap: they are loaded on entry and only decremented while nonzero.

## Timing
- Reset values:
  - `state_out`=0 (DISARMED); `ringing`=0; `buzzer`=0.
  - `snooze_left`=0; `snooze_count`=0.
  - `ring_left`=0; `beep`=0; `match_d`=0.
- Reset is asynchronous and applies mid-ring or mid-snooze. After release, the block restarts in DISARMED.
- All outputs are registered or decoded from registered state, with no input-to-output combinational path.
- `trigger` seen at edge N gives `ringing`=1 and `buzzer`=1 after edge N, i.e. one cycle after `match` first rises.
- Button pulse at edge N gives the new state after edge N.
- Ring duration: exactly `RING_SEC` ticks after entry, the block returns to ARMED.
- Snooze duration: exactly `SNOOZE_SEC` ticks after entry, the block re-rings.
- Arming while `match` is already high does not ring (no edge). The same holds for `match` persisting after `adjust_active` falls.

## Test plan
All scenarios use `SNOOZE_SEC`=3, `RING_SEC`=4, `MAX_SNOOZE`=2.
- Reset held low mid-RINGING: all outputs 0, `state_out`=0. Release with `alarm_enable`=1: ARMED next cycle.
- Armed, time steps 06:59 to 07:00 with alarm 07:00: `ringing`=1 one cycle later and `buzzer`=1. Then `buzzer` toggles 0,1,0 on ticks. The 4th tick gives ARMED with `ringing`=0. Time stays 07:00 and there is no re-ring.
- Ringing, up pulse: SNOOZE with `snooze_left`=3 and `snooze_count`=1. Ticks give 2, 1, then RINGING with `snooze_left`=0. Down pulse: `snooze_count`=2. Third snooze pulse while ringing is ignored (stays RINGING).
- Ringing, centre pulse and tick in the same cycle: ARMED, `snooze_count`=0, `ring_left` not decremented.
- Match edge while `adjust_active`=1: stays ARMED. In SNOOZE, `adjust_active` rises: ARMED next cycle.
- Ringing or snoozing, `alarm_enable` dropped together with a centre pulse: DISARMED, all counters 0. Re-enable while time==alarm: ARMED, no ring.

Source files
------------

// File: rtl/alarm_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alarm_sequencer: alarm ring/snooze/dismiss controller for the clock. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module alarm_sequencer #(
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3,
  parameter int CNT_W      = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic [4:0]       button_out,
  input  logic             alarm_enable,
  input  logic             adjust_active,
  input  logic [4:0]       time_hours,
  input  logic [4:0]       alarm_hours,
  input  logic [5:0]       time_minutes,
  input  logic [5:0]       alarm_minutes,
  output logic [1:0]       state_out,
  output logic             ringing,
  output logic             buzzer,
  output logic [CNT_W-1:0] snooze_left,
  output logic [2:0]       snooze_count
);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_RINGING  = 2'd2,
    S_SNOOZE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_RING_SEC   = CNT_W'(RING_SEC);
  localparam logic [CNT_W-1:0] C_SNOOZE_SEC = CNT_W'(SNOOZE_SEC);
  localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
  localparam logic [2:0]       C_MAX_SNOOZE = 3'(MAX_SNOOZE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ring_left_q, ring_left_d;
  logic [CNT_W-1:0] snooze_left_q, snooze_left_d;
  logic [2:0]       snooze_count_q, snooze_count_d;
  logic             beep_q, beep_d;
  logic             match_q;

  logic w_match, w_trigger, w_centre, w_snooze_btn;

  assign w_match      = (time_hours == alarm_hours) && (time_minutes == alarm_minutes);
  // Edge-only trigger: a dismiss inside the matching minute must not re-ring.
  assign w_trigger    = w_match && !match_q && !adjust_active;
  assign w_centre     = button_out[0];
  assign w_snooze_btn = |button_out[4:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_DISARMED;
      ring_left_q    <= '0;
      snooze_left_q  <= '0;
      snooze_count_q <= '0;
      beep_q         <= 1'b0;
      match_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      ring_left_q    <= ring_left_d;
      snooze_left_q  <= snooze_left_d;
      snooze_count_q <= snooze_count_d;
      beep_q         <= beep_d;
      match_q        <= w_match;
    end
  end

  always_comb begin
    state_d        = state_q;
    ring_left_d    = ring_left_q;
    snooze_left_d  = snooze_left_q;
    snooze_count_d = snooze_count_q;
    beep_d         = beep_q;

    if (!alarm_enable) begin
      state_d        = S_DISARMED;
      ring_left_d    = '0;
      snooze_left_d  = '0;
      snooze_count_d = '0;
    end else begin
      unique case (state_q)
        S_DISARMED: state_d = S_ARMED;
        S_ARMED: begin
          if (w_trigger) begin
            state_d     = S_RINGING;
            ring_left_d = C_RING_SEC;
            beep_d      = 1'b1;
          end
        end
        S_RINGING: begin
          if (adjust_active || w_centre) begin
            state_d        = S_ARMED;
            ring_left_d    = '0;
            snooze_count_d = '0;
          end else if (w_snooze_btn) begin
            // An exhausted snooze press is swallowed, along with any coincident tick.
            if (snooze_count_q < C_MAX_SNOOZE) begin
              state_d        = S_SNOOZE;
              snooze_left_d  = C_SNOOZE_SEC;
              snooze_count_d = snooze_count_q + 3'd1;
            end
          end else if (tick_1hz) begin
            if (ring_left_q == C_ONE) begin
              state_d        = S_ARMED;
              ring_left_d    = '0;
              snooze_count_d = '0;
            end else if (ring_left_q != '0) begin
              ring_left_d = ring_left_q - C_ONE;
              beep_d      = !beep_q;
            end
          end
        end
        S_SNOOZE: begin
          if (adjust_active || w_centre) begin
            state_d        = S_ARMED;
            snooze_left_d  = '0;
            snooze_count_d = '0;
          end else if (!w_snooze_btn && tick_1hz) begin
            if (snooze_left_q == C_ONE) begin
              state_d       = S_RINGING;
              snooze_left_d = '0;
              ring_left_d   = C_RING_SEC;
              beep_d        = 1'b1;
            end else if (snooze_left_q != '0) begin
              snooze_left_d = snooze_left_q - C_ONE;
            end
          end
        end
        default: state_d = S_DISARMED;
      endcase
    end
  end

  assign state_out    = state_q;
  assign ringing      = (state_q == S_RINGING);
  assign buzzer       = ringing && beep_q;
  assign snooze_left  = snooze_left_q;
  assign snooze_count = snooze_count_q;

endmodule
`default_nettype wire
